// File: rtl/mem_test_pkg.sv
// rtl/mem_test_pkg.sv - shared widths and FSM encoding for the RAM readback path
package mem_test_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_LOAD,
        S_SEND,
        S_DONE
    } rb_state_t;

    // Width of one packed RAM word: burst_index results of (no_of_digits+1) signed digits.
    function automatic int calc_w(input int no_of_digits, input int radix_bits, input int burst_index);
        return (no_of_digits + 1) * radix_bits * burst_index;
    endfunction

    function automatic int calc_nb(input int w);
        return (w + 7) / 8;
    endfunction

endpackage

// File: rtl/mem_readback_word_serializer.sv
// rtl/mem_readback_word_serializer.sv - word_serializer: wide word to byte stream with valid/ready
module word_serializer #(
    parameter int W  = 18,
    parameter int NB = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] data,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         last_xfer
);

    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(NB - 1);

    logic [NB*8-1:0] shreg;
    logic [CW-1:0]   byte_cnt;
    logic            xfer;

    assign xfer      = tx_valid && tx_ready;
    assign last_xfer = xfer && (byte_cnt == LAST_BYTE);
    // Output byte is always the low byte of the shift register, so it cannot move during a stall.
    assign tx_data   = shreg[7:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            shreg    <= '0;
            byte_cnt <= '0;
            tx_valid <= 1'b0;
        end else if (load) begin
            shreg    <= (NB*8)'(data);
            byte_cnt <= '0;
            tx_valid <= 1'b1;
        end else if (xfer) begin
            shreg    <= shreg >> 8;
            byte_cnt <= byte_cnt + CW'(1);
            if (byte_cnt == LAST_BYTE) begin
                tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_readback.sv
// rtl/mem_readback.sv - sweeps every RAM word and streams it out LSB byte first
module mem_readback
    import mem_test_pkg::*;
#(
    parameter int no_of_digits    = 8,
    parameter int radix_bits      = 3,
    parameter int burst_index     = 8,
    parameter int address_width   = 14,
    parameter int max_ram_address = 1024,
    parameter int ram_latency     = 2,
    localparam int W              = calc_w(no_of_digits, radix_bits, burst_index),
    localparam int NB             = calc_nb(W)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic [address_width-1:0] ram_addr,
    output logic                     ram_rden,
    input  logic [W-1:0]             ram_q,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     busy,
    output logic                     done
);

    localparam logic [address_width-1:0] LAST_ADDR = address_width'(max_ram_address - 1);
    localparam logic [7:0]               LAT_INIT  = 8'(ram_latency - 1);

    rb_state_t  state;
    logic [7:0] lat_cnt;
    logic       last_xfer;
    logic       load;

    assign load = (state == S_LOAD);

    word_serializer #(
        .W  (W),
        .NB (NB)
    ) u_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .data      (ram_q),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .last_xfer (last_xfer)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            ram_addr <= '0;
            ram_rden <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            lat_cnt  <= '0;
        end else begin
            ram_rden <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_ISSUE;
                        ram_addr <= '0;
                        ram_rden <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    lat_cnt <= LAT_INIT;
                    state   <= (ram_latency == 1) ? S_LOAD : S_WAIT;
                end
                S_WAIT: begin
                    lat_cnt <= lat_cnt - 8'd1;
                    if (lat_cnt == 8'd1) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    state <= S_SEND;
                end
                S_SEND: begin
                    // The next read is issued straight from the last handshake, so no bubble beyond ISSUE.
                    if (last_xfer) begin
                        if (ram_addr == LAST_ADDR) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            ram_addr <= ram_addr + address_width'(1);
                            ram_rden <= 1'b1;
                            state    <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    ram_addr <= '0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_readback.sv
// tb/tb_mem_readback.sv - randomized/model-checked bench for mem_readback at latency 2 and 1
module tb_mem_readback;

    localparam int W    = 18;
    localparam int NB   = 3;
    localparam int AW   = 2;
    localparam int MAXA = 4;

    logic clk;
    logic reset;
    logic start;
    logic tx_ready;

    logic [AW-1:0] o_addr [2];
    logic          o_rden [2];
    logic [7:0]    o_txd  [2];
    logic          o_txv  [2];
    logic          o_busy [2];
    logic          o_done [2];
    logic [W-1:0]  ram_q  [2];

    logic [W-1:0] mem [MAXA];
    logic [W-1:0] s1_0, s2_0, s1_1;

    int checks;
    int failures;
    int cyc;

    bit m_known  [2];
    bit m_active [2];
    int m_phase  [2];
    int m_pre    [2];
    int m_word   [2];
    int m_j      [2];

    logic [7:0] rx_log   [2][256];
    int         rx_cnt   [2];
    int         done_cnt [2];
    int         done_cyc [2];
    int         start_cyc[2];
    int         rden_log [2][64];
    int         rden_cnt [2];

    logic [7:0] exp_lit [12] = '{8'h05, 8'h03, 8'h02, 8'h06, 8'h04, 8'h02,
                                 8'h07, 8'h05, 8'h02, 8'h08, 8'h06, 8'h02};

    mem_readback #(
        .no_of_digits(2), .radix_bits(3), .burst_index(2),
        .address_width(AW), .max_ram_address(MAXA), .ram_latency(2)
    ) dut0 (
        .clk(clk), .reset(reset), .start(start),
        .ram_addr(o_addr[0]), .ram_rden(o_rden[0]), .ram_q(ram_q[0]),
        .tx_data(o_txd[0]), .tx_valid(o_txv[0]), .tx_ready(tx_ready),
        .busy(o_busy[0]), .done(o_done[0])
    );

    mem_readback #(
        .no_of_digits(2), .radix_bits(3), .burst_index(2),
        .address_width(AW), .max_ram_address(MAXA), .ram_latency(1)
    ) dut1 (
        .clk(clk), .reset(reset), .start(start),
        .ram_addr(o_addr[1]), .ram_rden(o_rden[1]), .ram_q(ram_q[1]),
        .tx_data(o_txd[1]), .tx_valid(o_txv[1]), .tx_ready(tx_ready),
        .busy(o_busy[1]), .done(o_done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int a = 0; a < MAXA; a++) mem[a] = 18'h2_0000 | (18'(a) * 18'h0101 + 18'h0305);
    end

    // RAM models: data is only meaningful exactly ram_latency cycles after rden, garbage otherwise.
    always @(posedge clk) begin
        s1_0 <= o_rden[0] ? mem[o_addr[0]] : 18'h3FFFF;
        s2_0 <= s1_0;
        s1_1 <= o_rden[1] ? mem[o_addr[1]] : 18'h3FFFF;
    end
    assign ram_q[0] = s2_0;
    assign ram_q[1] = s1_1;

    function automatic logic [7:0] exp_byte(input int a, input int j);
        int w;
        w = 32'h2_0000 | (a * 32'h0101 + 32'h0305);
        return 8'((w >> (8 * j)) & 32'hFF);
    endfunction

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, inst, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int  lat;
            int  e_addr;
            bit  e_busy, e_done, e_txv, e_rden;
            lat    = (i == 0) ? 2 : 1;
            e_busy = m_active[i];
            e_done = m_active[i] && m_phase[i] == 2;
            e_txv  = m_active[i] && m_phase[i] == 1;
            e_rden = m_active[i] && m_phase[i] == 0 && m_pre[i] == 0;
            e_addr = m_active[i] ? m_word[i] : 0;
            if (m_known[i]) begin
                chk("busy", i, 32'(o_busy[i]), 32'(e_busy));
                chk("done", i, 32'(o_done[i]), 32'(e_done));
                chk("tx_valid", i, 32'(o_txv[i]), 32'(e_txv));
                chk("ram_rden", i, 32'(o_rden[i]), 32'(e_rden));
                chk("ram_addr", i, 32'(o_addr[i]), 32'(e_addr));
                if (e_txv) chk("tx_data", i, 32'(o_txd[i]), 32'(exp_byte(m_word[i], m_j[i])));
                else if (!m_active[i]) chk("tx_data_idle", i, 32'(o_txd[i]), 32'h0);
                if (o_txv[i] === 1'b1 && tx_ready && rx_cnt[i] < 256) begin
                    rx_log[i][rx_cnt[i]] = o_txd[i];
                    rx_cnt[i]++;
                end
                if (o_done[i] === 1'b1) begin
                    done_cnt[i]++;
                    done_cyc[i] = cyc;
                end
                if (o_rden[i] === 1'b1) begin
                    rden_log[i][rden_cnt[i] % 64] = int'(o_addr[i]);
                    rden_cnt[i]++;
                end
            end
            if (!reset) begin
                m_known[i]  = 1'b1;
                m_active[i] = 1'b0;
            end else if (!m_active[i]) begin
                if (start) begin
                    m_active[i]  = 1'b1;
                    m_word[i]    = 0;
                    m_phase[i]   = 0;
                    m_pre[i]     = 0;
                    start_cyc[i] = cyc;
                end
            end else begin
                case (m_phase[i])
                    0: begin
                        if (m_pre[i] == lat) begin
                            m_phase[i] = 1;
                            m_j[i]     = 0;
                        end else m_pre[i]++;
                    end
                    1: begin
                        if (tx_ready) begin
                            m_j[i]++;
                            if (m_j[i] == NB) begin
                                if (m_word[i] == MAXA - 1) m_phase[i] = 2;
                                else begin
                                    m_word[i]++;
                                    m_phase[i] = 0;
                                    m_pre[i]   = 0;
                                end
                            end
                        end
                    end
                    default: m_active[i] = 1'b0;
                endcase
            end
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_idle(input int mode, input bit inject, input int budget);
        int n;
        n = 0;
        while ((m_active[0] || m_active[1]) && n < budget) begin
            case (mode)
                0: tx_ready = 1'b1;
                1: tx_ready = (n % 4 == 0) || (n % 4 == 3);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            start = inject && o_addr[0] == 2'd2 && o_busy[1];
            tick();
            n++;
        end
        start    = 1'b0;
        tx_ready = 1'b1;
        chk("sweep_finished", 0, 32'(n < budget), 32'd1);
    endtask

    task automatic sweep_counts(input string nm, input int rb0, input int db0, input int rb1, input int db1);
        chk({nm, "_bytes"}, 0, 32'(rx_cnt[0] - rb0), 32'd12);
        chk({nm, "_dones"}, 0, 32'(done_cnt[0] - db0), 32'd1);
        chk({nm, "_bytes"}, 1, 32'(rx_cnt[1] - rb1), 32'd12);
        chk({nm, "_dones"}, 1, 32'(done_cnt[1] - db1), 32'd1);
        for (int k = 0; k < 12; k++) begin
            chk({nm, "_lit"}, 0, 32'(rx_log[0][rb0 + k]), 32'(exp_lit[k]));
            chk({nm, "_lit"}, 1, 32'(rx_log[1][rb1 + k]), 32'(exp_lit[k]));
        end
    endtask

    initial begin
        int rb0, rb1, db0, db1, rdb, n;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        for (int i = 0; i < 2; i++) begin
            m_known[i] = 0; m_active[i] = 0; m_phase[i] = 0; m_pre[i] = 0;
            m_word[i] = 0; m_j[i] = 0; rx_cnt[i] = 0; done_cnt[i] = 0;
            done_cyc[i] = 0; start_cyc[i] = 0; rden_cnt[i] = 0;
        end
        reset    = 1'b0;
        start    = 1'b0;
        tx_ready = 1'b1;
        repeat (3) tick();
        chk("rst_addr", 0, 32'(o_addr[0]), 32'd0);
        chk("rst_rden", 0, 32'(o_rden[0]), 32'd0);
        chk("rst_txv", 0, 32'(o_txv[0]), 32'd0);
        chk("rst_txd", 0, 32'(o_txd[0]), 32'd0);
        chk("rst_busy", 0, 32'(o_busy[0]), 32'd0);
        chk("rst_done", 0, 32'(o_done[0]), 32'd0);
        reset = 1'b1;
        tick();

        // Plain sweep with the host always ready.
        rb0 = rx_cnt[0]; rb1 = rx_cnt[1]; db0 = done_cnt[0]; db1 = done_cnt[1]; rdb = rden_cnt[1];
        start = 1'b1;
        tick();
        start = 1'b0;
        run_idle(0, 1'b0, 300);
        sweep_counts("ready_high", rb0, db0, rb1, db1);
        chk("sweep_cycles", 0, 32'(done_cyc[0] - start_cyc[0]), 32'd25);
        chk("sweep_cycles", 1, 32'(done_cyc[1] - start_cyc[1]), 32'd21);
        chk("rden_pulses", 1, 32'(rden_cnt[1] - rdb), 32'd4);
        for (int k = 0; k < 4; k++) chk("rden_addr", 1, 32'(rden_log[1][(rdb + k) % 64]), 32'(k));
        chk("idle_busy", 0, 32'(o_busy[0]), 32'd0);

        // Stalling host plus a start pulse injected mid-sweep.
        rb0 = rx_cnt[0]; rb1 = rx_cnt[1]; db0 = done_cnt[0]; db1 = done_cnt[1];
        start = 1'b1;
        tick();
        start = 1'b0;
        run_idle(1, 1'b1, 500);
        sweep_counts("stall_pattern", rb0, db0, rb1, db1);

        // Random backpressure.
        for (int r = 0; r < 2; r++) begin
            rb0 = rx_cnt[0]; rb1 = rx_cnt[1]; db0 = done_cnt[0]; db1 = done_cnt[1];
            start = 1'b1;
            tick();
            start = 1'b0;
            run_idle(2, 1'b0, 800);
            sweep_counts("random_ready", rb0, db0, rb1, db1);
        end

        // Reset while byte 1 of address 1 is on the link.
        rb0 = rx_cnt[0]; db0 = done_cnt[0];
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(rx_cnt[0] - rb0 == 4 && o_txv[0] === 1'b1) && n < 100) begin
            tick();
            n++;
        end
        chk("reach_byte4", 0, 32'(n < 100), 32'd1);
        chk("byte4_value", 0, 32'(o_txd[0]), 32'h04);
        reset = 1'b0;
        tick();
        chk("abort_addr", 0, 32'(o_addr[0]), 32'd0);
        chk("abort_txv", 0, 32'(o_txv[0]), 32'd0);
        chk("abort_txd", 0, 32'(o_txd[0]), 32'd0);
        chk("abort_busy", 0, 32'(o_busy[0]), 32'd0);
        reset = 1'b1;
        tick();
        tick();
        chk("abort_no_done", 0, 32'(done_cnt[0] - db0), 32'd0);
        rb0 = rx_cnt[0]; rb1 = rx_cnt[1]; db0 = done_cnt[0]; db1 = done_cnt[1];
        start = 1'b1;
        tick();
        start = 1'b0;
        run_idle(0, 1'b0, 300);
        chk("restart_first", 0, 32'(rx_log[0][rb0]), 32'h05);
        sweep_counts("after_abort", rb0, db0, rb1, db1);

        // Start held for two cycles runs exactly one sweep.
        rb0 = rx_cnt[0]; rb1 = rx_cnt[1]; db0 = done_cnt[0]; db1 = done_cnt[1];
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        run_idle(0, 1'b0, 300);
        repeat (3) tick();
        sweep_counts("start_held", rb0, db0, rb1, db1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
